// File: rtl/capdriver_seq_if.sv
// Bundles the capacitor-DAC driver's request inputs and switch/status outputs.
// The master side issues requests; the slave side is the sequencer itself.
interface capdriver_seq_if #(
    parameter int unsigned Ndac = 16
);
    logic [Ndac-1:0] dac_state;
    logic            dac_drive_invert;
    logic            load;
    logic            clear;
    logic [Ndac-1:0] dac_drive_p;
    logic [Ndac-1:0] dac_drive_n;
    logic            busy;
    logic            done;

    modport master (
        output dac_state, dac_drive_invert, load, clear,
        input  dac_drive_p, dac_drive_n, busy, done
    );

    modport slave (
        input  dac_state, dac_drive_invert, load, clear,
        output dac_drive_p, dac_drive_n, busy, done
    );
endinterface

// File: rtl/capdriver_seq.sv
// Break-before-make sequencer for capacitor-DAC bottom-plate switches.
// Bits that change are first opened (p=n=0) for DEAD cycles, then all bits
// are driven to the new code, then the array settles for SETTLE cycles
// before done pulses.
module capdriver_seq #(
    parameter int unsigned     Ndac       = 16,
    parameter int unsigned     DEAD       = 1,
    parameter int unsigned     SETTLE     = 2,
    parameter logic [Ndac-1:0] RESET_CODE = {1'b1, {(Ndac-1){1'b0}}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    capdriver_seq_if.slave        bus
);

    // One counter serves both phases, so it must hold the larger of the two.
    localparam int unsigned MAXC = (DEAD > SETTLE) ? DEAD : SETTLE;
    localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [Ndac-1:0] target_q, target_d;
    logic [Ndac-1:0] p_q, p_d;
    logic [Ndac-1:0] n_q, n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept;
    logic [Ndac-1:0] new_target;
    logic [Ndac-1:0] changed;

    // clear is honoured in every state; load only when no update is running.
    assign accept     = bus.clear | (bus.load & (state_q == ST_IDLE));
    assign new_target = bus.clear ? RESET_CODE
                      : (bus.dac_drive_invert ? ~bus.dac_state : bus.dac_state);
    // A bit is already correct only if p matches the target and n its inverse;
    // a bit left open by an aborted update therefore counts as changed.
    assign changed    = ~((p_q ~^ new_target) & (n_q ^ new_target));

    // Next-state, drive and status computation for the update sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        p_d      = p_q;
        n_d      = n_q;
        done_d   = 1'b0;

        if (accept) begin
            target_d = new_target;
            cnt_d    = ONE_C;
            if (DEAD == 0) begin
                p_d     = new_target;
                n_d     = ~new_target;
                state_d = ST_SETTLE;
            end else begin
                p_d     = p_q & ~changed;
                n_d     = n_q & ~changed;
                state_d = ST_BREAK;
            end
        end else begin
            case (state_q)
                ST_BREAK: begin
                    if (cnt_q == DEAD_C) begin
                        p_d     = target_q;
                        n_d     = ~target_q;
                        cnt_d   = ONE_C;
                        state_d = ST_SETTLE;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_C) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset parks the switches at RESET_CODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= RESET_CODE;
            p_q      <= RESET_CODE;
            n_q      <= ~RESET_CODE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            p_q      <= p_d;
            n_q      <= n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.dac_drive_p = p_q;
    assign bus.dac_drive_n = n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
